ifm_bram_ctrl: RTL and testbench
================================

# ifm_bram_ctrl

Sequencer for the single-clock IFM buffer (128-bit write rows, 32-bit read words, word address = row*4 + lane). It owns the buffer's write-enable and both address buses. It loads a burst of 128-bit rows from an upstream stream, then plays back a contiguous range of 32-bit words to the PE array through a valid/ready port. Load and playback are mutually exclusive phases, so compute never sees a half-written tile.

## Interface
- ADDR_W, 32: width of buffer addresses and base/length fields
- LEN_W, 16: width of row/word count fields
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous reset, active-high
- load_start  in  1  pulse: begin load of load_rows rows at load_base (row address)
- load_base  in  ADDR_W  first row address, sampled with load_start
- load_rows  in  LEN_W  row count, sampled with load_start
- s_valid / s_ready  in / out  1  upstream 128-bit row handshake
- s_data  in  128  row data
- rd_start  in  1  pulse: begin playback
- rd_base  in  ADDR_W  first word address, sampled with rd_start
- rd_len  in  LEN_W  word count, sampled with rd_start
- m_valid / m_ready  out / in  1  downstream 32-bit word handshake
- m_data  out  32  word data
- bram_wr_rd_en  out  1  buffer write strobe
- bram_wr_addr  out  ADDR_W  buffer row address
- bram_rd_addr  out  ADDR_W  buffer word address
- bram_wdata  out  128  buffer write data
- bram_rdata  in  32  buffer read data, valid 1 cycle after bram_rd_addr
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at end of load or playback

## Operation
- FSM states: IDLE, LOAD, READ, DRAIN.
- IDLE: load_start has priority over rd_start if both are high. A count of 0 produces a done pulse next cycle and stays in IDLE. Start pulses outside IDLE are ignored.
- LOAD:
  - s_ready = 1.
  - On s_valid && s_ready: bram_wr_rd_en = 1, bram_wr_addr = load_base + row_cnt, bram_wdata = s_data (combinational pass-through), row_cnt++.
  - After the last row is accepted: next state IDLE, done pulse.
- READ:
  - Issue word reads to bram_rd_addr = rd_base + issue_cnt, one per cycle, while credit > 0.
  - credit = 2 − (skid occupancy + reads in flight).
  - Returned words enter the 2-entry skid FIFO, which drives m_valid/m_data.
  - After the last issue: go to DRAIN.
- DRAIN: wait until the in-flight read has landed and the FIFO is empty, then IDLE with a done pulse.
- Address arithmetic is modulo 2^ADDR_W, so wrap is silent. Counters are LEN_W bits. A count of 2^LEN_W−1 is legal.
- bram_wr_rd_en = 0 in every state except LOAD on an accepted beat. No write can occur during READ or DRAIN.
- Reset values: s_ready 0, m_valid 0, busy 0, done 0, bram_wr_rd_en 0, all addresses 0, FIFO empty, state IDLE.
- Reset mid-operation aborts the phase without a done pulse. It discards in-flight and FIFO data, and no further writes occur.

## Timing
- Load throughput: 1 row/cycle. done is asserted the cycle after the last accepted beat.
- Playback latency: rd_start at cycle T → first bram_rd_addr at T+1 → m_valid at T+2.
- Playback throughput: 1 word/cycle with m_ready held high.
- m_data/m_valid are held stable while m_valid && !m_ready.
- Backpressure never loses a word. With 2 credits, issue resumes the cycle after a pop.
- done (playback) is asserted the cycle after the last word's handshake.

## Structure
- Shared package ifm_ctrl_pkg holds:
  - the state enum (IDLE, LOAD, READ, DRAIN)
  - the constants ROW_W = 128, WORD_W = 32, WORDS_PER_ROW = 4
- Sub-module ifm_skid_fifo: 2-entry, 32-bit, synchronous FIFO with push/pop/count. It is instantiated once for the output path.

## Test plan
- Load 4 rows at load_base 0x10 with s_valid always high → writes to rows 0x10..0x13 on 4 consecutive cycles; done 1 cycle after the last beat; s_ready low afterwards.
- Load 3 rows with s_valid gaps → exactly 3 writes, addresses contiguous, no write strobe during gaps.
- Play rd_base 0x41, rd_len 6, m_ready high → bram_rd_addr 0x41..0x46 on consecutive cycles; first m_valid 2 cycles after rd_start; words in order; done after the 6th word.
- Play 8 words with m_ready toggled randomly and held low 5 cycles → no drop or duplicate; at most 2 issued-but-unconsumed words; m_data stable while stalled.
- load_start and rd_start asserted together, then rd_start during LOAD → the load executes, both rd_start pulses are ignored, and no read is issued.
- rst asserted mid-READ with a full FIFO → next cycle m_valid 0, busy 0, no done pulse; a subsequent 2-word playback is correct.

Source files
------------

// File: rtl/ifm_ctrl_pkg.sv
// ifm_ctrl_pkg
// Shared definitions for the IFM buffer sequencer: the controller state
// encoding and the buffer geometry (128-bit rows split into four 32-bit words).
package ifm_ctrl_pkg;

    localparam int ROW_W         = 128;
    localparam int WORD_W        = 32;
    localparam int WORDS_PER_ROW = 4;

    // Load and playback are separate phases; DRAIN waits for the output path
    // to empty before the controller accepts a new command.
    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        READ,
        DRAIN
    } state_t;

endpackage

// File: rtl/ifm_skid_fifo.sv
// ifm_skid_fifo
// Two-entry synchronous FIFO that buffers 32-bit words returned by the
// buffer while the downstream consumer is stalled.
// Ports:
//   clk, rst   clock and synchronous active-high reset (empties the FIFO)
//   push, din  write a word (ignored when full unless a pop happens together)
//   pop        remove the head word (ignored when empty)
//   dout       head word, meaningful while count != 0
//   count      number of stored words, 0..2
module ifm_skid_fifo
    import ifm_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [WORD_W-1:0] din,
    output logic [WORD_W-1:0] dout,
    output logic [1:0]        count
);

    logic [WORD_W-1:0] mem [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic              do_push;
    logic              do_pop;

    // A push into a full FIFO is only legal when the head leaves in the same
    // cycle, so both qualifiers are resolved here once.
    always_comb begin
        do_pop  = pop && (count != 2'd0);
        do_push = push && ((count != 2'd2) || do_pop);
        dout    = mem[rd_ptr];
    end

    // Storage carries no reset; occupancy and pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; reset leaves the FIFO empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ifm_bram_ctrl.sv
// ifm_bram_ctrl
// Sequencer for the IFM buffer. It loads a burst of 128-bit rows from an
// upstream stream, then plays back a contiguous range of 32-bit words to the
// PE array. The two phases never overlap, so compute never reads a tile that
// is still being written.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   load_start/load_base/load_rows  start a row load (base is a row address)
//   s_valid/s_ready/s_data        upstream 128-bit row handshake
//   rd_start/rd_base/rd_len       start a playback (base is a word address)
//   m_valid/m_ready/m_data        downstream 32-bit word handshake
//   bram_wr_rd_en/bram_wr_addr/bram_wdata  buffer write port (row granular)
//   bram_rd_addr/bram_rdata       buffer read port, one cycle read latency
//   busy                          a phase is in progress
//   done                          one-cycle pulse when a phase completes
module ifm_bram_ctrl
    import ifm_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic [ADDR_W-1:0] load_base,
    input  logic [LEN_W-1:0]  load_rows,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [ROW_W-1:0]  s_data,
    input  logic              rd_start,
    input  logic [ADDR_W-1:0] rd_base,
    input  logic [LEN_W-1:0]  rd_len,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [WORD_W-1:0] m_data,
    output logic              bram_wr_rd_en,
    output logic [ADDR_W-1:0] bram_wr_addr,
    output logic [ADDR_W-1:0] bram_rd_addr,
    output logic [ROW_W-1:0]  bram_wdata,
    input  logic [WORD_W-1:0] bram_rdata,
    output logic              busy,
    output logic              done
);

    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    state_t            state;
    state_t            next_state;
    logic [ADDR_W-1:0] load_base_q;
    logic [ADDR_W-1:0] rd_base_q;
    logic [LEN_W-1:0]  load_rows_q;
    logic [LEN_W-1:0]  rd_len_q;
    logic [LEN_W-1:0]  row_cnt;
    logic [LEN_W-1:0]  issue_cnt;
    logic              in_flight;
    logic              done_q;
    logic              beat;
    logic              last_beat;
    logic              issue;
    logic              last_issue;
    logic              drain_done;
    logic [1:0]        occupancy;
    logic              fifo_push;
    logic              fifo_pop;
    logic [WORD_W-1:0] fifo_dout;
    logic [1:0]        fifo_count;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. Loads win over playback when both start together;
    // zero-length commands finish without leaving IDLE.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (load_start) begin
                    next_state = (load_rows == '0) ? IDLE : LOAD;
                end else if (rd_start) begin
                    next_state = (rd_len == '0) ? IDLE : READ;
                end
            end
            LOAD:  if (beat && last_beat)   next_state = IDLE;
            READ:  if (issue && last_issue) next_state = DRAIN;
            DRAIN: if (drain_done)          next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output and handshake decode. A read may be issued only while the words
    // already owed to the consumer (stored plus in flight) leave room in the
    // two-entry FIFO, so a stalled consumer can never cause an overflow.
    // When the FIFO is empty the landing word is presented straight from the
    // buffer, which gives two-cycle start latency; if it is not taken it is
    // parked in the FIFO so m_data stays stable.
    always_comb begin
        s_ready       = (state == LOAD);
        beat          = s_ready && s_valid;
        last_beat     = (row_cnt == load_rows_q - LEN_ONE);
        bram_wr_rd_en = beat;
        bram_wr_addr  = load_base_q + ADDR_W'(row_cnt);
        bram_wdata    = s_data;
        bram_rd_addr  = rd_base_q + ADDR_W'(issue_cnt);
        occupancy     = fifo_count + {1'b0, in_flight};
        issue         = (state == READ) && (occupancy < 2'd2);
        last_issue    = (issue_cnt == rd_len_q - LEN_ONE);
        drain_done    = (state == DRAIN) && (fifo_count == 2'd0) && !in_flight;
        m_valid       = (fifo_count != 2'd0) || in_flight;
        m_data        = (fifo_count != 2'd0) ? fifo_dout : bram_rdata;
        fifo_pop      = (fifo_count != 2'd0) && m_ready;
        fifo_push     = in_flight && !((fifo_count == 2'd0) && m_ready);
        busy          = (state != IDLE);
        done          = done_q || drain_done;
    end

    // Command capture, row/word counters and the read-in-flight flag. The
    // load done pulse is registered so it lands the cycle after the last beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            load_base_q <= '0;
            rd_base_q   <= '0;
            load_rows_q <= '0;
            rd_len_q    <= '0;
            row_cnt     <= '0;
            issue_cnt   <= '0;
            in_flight   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q    <= beat && last_beat;
            in_flight <= issue;
            if (issue) begin
                issue_cnt <= issue_cnt + LEN_ONE;
            end
            if (beat) begin
                row_cnt <= row_cnt + LEN_ONE;
            end
            if (state == IDLE) begin
                if (load_start) begin
                    load_base_q <= load_base;
                    load_rows_q <= load_rows;
                    row_cnt     <= '0;
                    done_q      <= (load_rows == '0);
                end else if (rd_start) begin
                    rd_base_q <= rd_base;
                    rd_len_q  <= rd_len;
                    issue_cnt <= '0;
                    done_q    <= (rd_len == '0);
                end
            end
        end
    end

    ifm_skid_fifo u_skid_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (bram_rdata),
        .dout  (fifo_dout),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_ifm_bram_ctrl.sv
// tb_ifm_bram_ctrl
// Self-checking bench for ifm_bram_ctrl. A behavioural buffer answers the
// controller's reads; a reference memory holds what the buffer should contain
// after the commands the bench issued, and a per-cycle monitor compares the
// DUT's writes, words, done/busy/s_ready and stall behaviour against it.
module tb_ifm_bram_ctrl;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_start;
    logic [31:0]   load_base;
    logic [15:0]   load_rows;
    logic          s_valid;
    logic          s_ready;
    logic [127:0]  s_data;
    logic          rd_start;
    logic [31:0]   rd_base;
    logic [15:0]   rd_len;
    logic          m_valid;
    logic          m_ready;
    logic [31:0]   m_data;
    logic          bram_wr_rd_en;
    logic [31:0]   bram_wr_addr;
    logic [31:0]   bram_rd_addr;
    logic [127:0]  bram_wdata;
    logic [31:0]   bram_rdata;
    logic          busy;
    logic          done;

    int num_checks = 0;
    int num_errors = 0;

    logic [31:0]  bram_mem [logic [31:0]];
    logic [31:0]  ref_mem  [logic [31:0]];
    logic [31:0]  exp_wr_addr [$];
    logic [127:0] exp_wr_data [$];
    logic [31:0]  exp_rd [$];

    logic        load_armed = 1'b0;
    logic        load_active = 1'b0;
    logic        play_armed = 1'b0;
    logic        play_busy = 1'b0;
    logic        zero_req = 1'b0;
    logic        done_pending = 1'b0;
    logic        done_from_play = 1'b0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = '0;
    logic [31:0] play_base = '0;
    int          consumed = 0;

    logic [31:0] drv_base = '0;
    int          beat_idx = 0;
    int          rel = 0;
    int          first_valid = -1;
    int          done_cyc = -1;
    logic [31:0] wr_log [$];
    int          wr_cyc_log [$];
    logic [31:0] rd_log [$];
    logic [31:0] hs_log [$];

    always #5 clk = ~clk;

    ifm_bram_ctrl #(.ADDR_W(32), .LEN_W(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .load_start    (load_start),
        .load_base     (load_base),
        .load_rows     (load_rows),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_data        (s_data),
        .rd_start      (rd_start),
        .rd_base       (rd_base),
        .rd_len        (rd_len),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_data        (m_data),
        .bram_wr_rd_en (bram_wr_rd_en),
        .bram_wr_addr  (bram_wr_addr),
        .bram_rd_addr  (bram_rd_addr),
        .bram_wdata    (bram_wdata),
        .bram_rdata    (bram_rdata),
        .busy          (busy),
        .done          (done)
    );

    // Word contents: never-written words hold a hash of their address, loaded
    // words hold a tag plus the low address bits so they are easy to spot.
    function automatic logic [31:0] pattern_val(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
    endfunction

    function automatic logic [31:0] loaded_val(input logic [31:0] a);
        return 32'hC3C3_0000 + {16'h0000, a[15:0]};
    endfunction

    function automatic logic [127:0] make_row(input logic [31:0] row);
        logic [127:0] r;
        for (int l = 0; l < 4; l++) begin
            r[32*l +: 32] = loaded_val((row << 2) + 32'(l));
        end
        return r;
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : pattern_val(a);
    endfunction

    function automatic logic ready_for(input int mode, input int c);
        if (mode == 0) return 1'b1;
        if (c >= 3 && c <= 7) return 1'b0;
        return 1'($urandom_range(0, 1));
    endfunction

    // Behavioural buffer: row writes split into four lanes, one-cycle reads.
    always @(posedge clk) begin
        if (bram_wr_rd_en) begin
            for (int l = 0; l < 4; l++) begin
                bram_mem[(bram_wr_addr << 2) + 32'(l)] = bram_wdata[32*l +: 32];
            end
        end
        bram_rdata <= bram_mem.exists(bram_rd_addr) ? bram_mem[bram_rd_addr]
                                                    : pattern_val(bram_rd_addr);
    end

    task automatic checkOutput(input string name, input logic [127:0] actual,
                               input logic [127:0] expected);
        num_checks++;
        if (actual !== expected) begin
            num_errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Reference model of a load command: which rows get written with what.
    task automatic model_load(input logic [31:0] base, input int rows);
        for (int r = 0; r < rows; r++) begin
            logic [31:0] ra;
            ra = base + 32'(r);
            exp_wr_addr.push_back(ra);
            exp_wr_data.push_back(make_row(ra));
            for (int l = 0; l < 4; l++) begin
                ref_mem[(ra << 2) + 32'(l)] = loaded_val((ra << 2) + 32'(l));
            end
        end
        drv_base = base;
        beat_idx = 0;
        if (rows == 0) zero_req = 1'b1;
        else load_armed = 1'b1;
    endtask

    // Reference model of a playback command: the ordered words owed downstream.
    task automatic model_play(input logic [31:0] base, input int len);
        for (int i = 0; i < len; i++) begin
            exp_rd.push_back(ref_word(base + 32'(i)));
        end
        play_base = base;
        consumed  = 0;
        if (len == 0) zero_req = 1'b1;
        else play_armed = 1'b1;
    endtask

    task automatic clear_logs();
        rel = 0;
        first_valid = -1;
        done_cyc = -1;
        wr_log.delete();
        wr_cyc_log.delete();
        rd_log.delete();
        hs_log.delete();
    endtask

    // Drive one cycle of inputs (called #1 after a rising edge), record what
    // the DUT shows at the falling edge, and return #1 after the next edge.
    task automatic applyStimulus(input logic ls, input logic rs, input logic sv,
                                 input logic mr, input logic rr);
        load_start = ls;
        rd_start   = rs;
        s_valid    = sv;
        m_ready    = mr;
        rst        = rr;
        s_data     = make_row(drv_base + 32'(beat_idx));
        @(negedge clk);
        if (bram_wr_rd_en) begin
            wr_log.push_back(bram_wr_addr);
            wr_cyc_log.push_back(rel);
        end
        rd_log.push_back(bram_rd_addr);
        if (m_valid && first_valid < 0) first_valid = rel;
        if (done && done_cyc < 0) done_cyc = rel;
        if (m_valid && m_ready) hs_log.push_back(m_data);
        if (s_valid && s_ready) beat_idx++;
        rel++;
        @(posedge clk);
        #1;
    endtask

    task automatic run_load(input logic [31:0] base, input logic [15:0] rows,
                            input int gap_mode);
        load_base = base;
        load_rows = rows;
        clear_logs();
        model_load(base, int'(rows));
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int c = 1; c < 100 && done_cyc < 0; c++) begin
            applyStimulus(1'b0, 1'b0, (gap_mode == 0) ? 1'b1 : (c % 3 == 1), 1'b1, 1'b0);
        end
        checkOutput("load_done_seen", 128'(done_cyc >= 0), 128'd1);
    endtask

    task automatic run_play(input logic [31:0] base, input logic [15:0] len,
                            input int mode);
        rd_base = base;
        rd_len  = len;
        clear_logs();
        model_play(base, int'(len));
        applyStimulus(1'b0, 1'b1, 1'b0, ready_for(mode, 0), 1'b0);
        for (int c = 1; c < 200 && done_cyc < 0; c++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, ready_for(mode, c), 1'b0);
        end
        checkOutput("play_done_seen", 128'(done_cyc >= 0), 128'd1);
    endtask

    // Per-cycle compare against the reference model.
    always @(negedge clk) begin
        logic exp_done;
        if (rst) begin
            exp_wr_addr.delete();
            exp_wr_data.delete();
            exp_rd.delete();
            load_armed = 1'b0;
            load_active = 1'b0;
            play_armed = 1'b0;
            play_busy = 1'b0;
            zero_req = 1'b0;
            done_pending = 1'b0;
            done_from_play = 1'b0;
            prev_stall = 1'b0;
        end else begin
            exp_done = done_pending;
            done_pending = 1'b0;
            if (prev_stall) begin
                checkOutput("stall_m_valid", m_valid, 1'b1);
                checkOutput("stall_m_data", m_data, prev_data);
            end
            checkOutput("done", done, exp_done);
            checkOutput("busy", busy, load_active || play_busy);
            checkOutput("s_ready", s_ready, load_active);
            if (!play_busy) checkOutput("m_valid_outside_play", m_valid, 1'b0);
            if (exp_done && done_from_play) begin
                play_busy = 1'b0;
                done_from_play = 1'b0;
            end
            checkOutput("wr_en", bram_wr_rd_en, s_valid && load_active);
            if (bram_wr_rd_en && exp_wr_addr.size() > 0) begin
                checkOutput("wr_addr", bram_wr_addr, exp_wr_addr.pop_front());
                checkOutput("wr_data", bram_wdata, exp_wr_data.pop_front());
                if (exp_wr_addr.size() == 0 && load_active) begin
                    load_active = 1'b0;
                    done_pending = 1'b1;
                end
            end
            if (play_busy) begin
                checkOutput("outstanding_le_2",
                            128'((bram_rd_addr - play_base - 32'(consumed)) <= 32'd2), 128'd1);
            end
            if (m_valid && m_ready) begin
                if (exp_rd.size() == 0) begin
                    num_checks++;
                    num_errors++;
                    $display("[TB] FAIL extra_word: got 0x%0h, expected no word", m_data);
                end else begin
                    checkOutput("m_data", m_data, exp_rd.pop_front());
                    consumed++;
                    if (exp_rd.size() == 0 && play_busy) begin
                        done_pending = 1'b1;
                        done_from_play = 1'b1;
                    end
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            if (load_armed) load_active = 1'b1;
            if (play_armed) play_busy = 1'b1;
            load_armed = 1'b0;
            play_armed = 1'b0;
            if (zero_req) done_pending = 1'b1;
            zero_req = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] saved_rd;
        int          rd_moves;
        rst = 1'b1;
        load_start = 1'b0;
        rd_start = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b0;
        s_data = '0;
        load_base = '0;
        load_rows = '0;
        rd_base = '0;
        rd_len = '0;
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Reset values.
        checkOutput("rst_s_ready", s_ready, 1'b0);
        checkOutput("rst_m_valid", m_valid, 1'b0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_done", done, 1'b0);
        checkOutput("rst_wr_en", bram_wr_rd_en, 1'b0);
        checkOutput("rst_wr_addr", bram_wr_addr, 32'h0);
        checkOutput("rst_rd_addr", bram_rd_addr, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] load 4 rows at 0x10, s_valid held high");
        run_load(32'h10, 16'd4, 0);
        checkOutput("t1_writes", 128'(wr_log.size()), 128'd4);
        checkOutput("t1_first_addr", wr_log[0], 32'h10);
        checkOutput("t1_last_addr", wr_log[3], 32'h13);
        checkOutput("t1_first_cyc", 128'(wr_cyc_log[0]), 128'd1);
        checkOutput("t1_last_cyc", 128'(wr_cyc_log[3]), 128'd4);
        checkOutput("t1_done_cyc", 128'(done_cyc), 128'd5);
        checkOutput("t1_s_ready_after", s_ready, 1'b0);

        $display("[TB] load 3 rows at 0x20 with s_valid gaps");
        run_load(32'h20, 16'd3, 1);
        checkOutput("t2_writes", 128'(wr_log.size()), 128'd3);
        checkOutput("t2_addr1", wr_log[1], 32'h21);
        checkOutput("t2_addr2", wr_log[2], 32'h22);
        checkOutput("t2_done_cyc", 128'(done_cyc), 128'd8);

        $display("[TB] play 6 words from 0x41, m_ready high");
        run_play(32'h41, 16'd6, 0);
        for (int c = 1; c <= 6; c++) begin
            checkOutput("t3_rd_addr", rd_log[c], 32'h41 + 32'(c - 1));
        end
        checkOutput("t3_first_valid", 128'(first_valid), 128'd2);
        checkOutput("t3_first_word", hs_log[0], 32'hC3C3_0041);
        checkOutput("t3_words", 128'(hs_log.size()), 128'd6);
        checkOutput("t3_done_cyc", 128'(done_cyc), 128'd8);

        $display("[TB] play 8 words from 0x7C with m_ready backpressure");
        run_play(32'h7C, 16'd8, 1);
        checkOutput("t4_words", 128'(hs_log.size()), 128'd8);
        checkOutput("t4_left_over", 128'(exp_rd.size()), 128'd0);
        checkOutput("t4_word4", hs_log[4], 32'hC3C3_0080);

        $display("[TB] load_start with rd_start, then rd_start during load");
        saved_rd = bram_rd_addr;
        load_base = 32'h5;
        load_rows = 16'd2;
        rd_base = 32'h99;
        rd_len = 16'd3;
        clear_logs();
        model_load(32'h5, 2);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int c = 2; c < 50 && done_cyc < 0; c++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        rd_moves = 0;
        foreach (rd_log[i]) if (rd_log[i] !== saved_rd) rd_moves++;
        checkOutput("t5_writes", 128'(wr_log.size()), 128'd2);
        checkOutput("t5_done_cyc", 128'(done_cyc), 128'd4);
        checkOutput("t5_rd_addr_moves", 128'(rd_moves), 128'd0);
        checkOutput("t5_no_m_valid", 128'(first_valid), 128'(-1));

        $display("[TB] zero-length load and playback");
        load_base = 32'h300;
        load_rows = 16'd0;
        clear_logs();
        model_load(32'h300, 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("t6_load_done_cyc", 128'(done_cyc), 128'd1);
        run_play(32'h500, 16'd0, 0);
        checkOutput("t6_play_done_cyc", 128'(done_cyc), 128'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        $display("[TB] playback across the address wrap");
        run_play(32'hFFFF_FFFF, 16'd2, 0);
        checkOutput("t7_addr_top", rd_log[1], 32'hFFFF_FFFF);
        checkOutput("t7_addr_wrap", rd_log[2], 32'h0);
        checkOutput("t7_word_wrap", hs_log[1], pattern_val(32'h0));

        $display("[TB] reset during playback with a full FIFO");
        rd_base = 32'h200;
        rd_len = 16'd10;
        clear_logs();
        model_play(32'h200, 10);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int c = 1; c < 5; c++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("t8_credit_addr3", rd_log[3], 32'h202);
        checkOutput("t8_credit_addr4", rd_log[4], 32'h202);
        checkOutput("t8_m_valid", m_valid, 1'b0);
        checkOutput("t8_busy", busy, 1'b0);
        checkOutput("t8_done", done, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        run_play(32'h41, 16'd2, 0);
        checkOutput("t8_word0", hs_log[0], 32'hC3C3_0041);
        checkOutput("t8_word1", hs_log[1], 32'hC3C3_0042);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule
